victim_cache_ctrl: RTL
======================

// Module: victim_cache_ctrl
// PURPOSE
//  Control FSM for the 8-way fully-associative victim cache; drives the VC tag array directly.
//  Accepts L1 evictions (insert) and L1-miss probes (lookup, swap-out on hit).
//  Chooses the replacement way: lowest invalid way first, else tree pseudo-LRU.
//  Issues dirty-victim writebacks to memory before the way is overwritten.
// PARAMETERS
//  WAYS_VC  8   number of VC ways; the PLRU tree is fixed for 8
//  WAY_W    3   way index width, $clog2(WAYS_VC)
//  TAG_W    27  VC tag width (TAGMSB_VC-TAGLSB_VC+1)
// PORTS
//  clk_i           in   1      clock
//  rst_ni          in   1      reset, synchronous, active-low
//  evict_valid_i   in   1      L1 presents an evicted line
//  evict_ready_o   out  1      controller accepts eviction
//  evict_tag_i     in   TAG_W  tag of evicted line
//  evict_dirty_i   in   1      evicted line is dirty
//  lookup_valid_i  in   1      L1 miss probe
//  lookup_ready_o  out  1      controller accepts probe
//  lookup_tag_i    in   TAG_W  probe tag
//  resp_valid_o    out  1      1-cycle lookup response strobe
//  resp_hit_o      out  1      probe hit
//  resp_way_o      out  WAY_W  hit way
//  resp_dirty_o    out  1      hit line dirty
//  tag_we_o        out  1      tag array write enable
//  tag_way_o       out  WAY_W  to tag array address_way_i
//  tag_addr_o      out  TAG_W  to tag array cpu_address_i tag field
//  tag_wr_valid_o  out  1      write data valid bit
//  tag_wr_dirty_o  out  1      write data dirty bit
//  tag_wr_tag_o    out  TAG_W  write data tag
//  tag_hit_i       in   1      OR of array hit vector
//  tag_hit_way_i   in   WAY_W  array address_way_o
//  tag_rd_dirty_i  in   1      array tag_read_o.dirty
//  tag_rd_tag_i    in   TAG_W  array tag_read_o.tag
//  full_i          in   1      array full_o
//  wb_valid_o      out  1      dirty victim writeback request
//  wb_ready_i      in   1      memory accepts writeback
//  wb_tag_o        out  TAG_W  victim tag
//  wb_way_o        out  WAY_W  victim way
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge):
//   - state=FLUSH, flush counter=0, PLRU=0, shadow valid[7:0]=0.
//   - All outputs 0; an in-flight writeback is dropped (wb_valid_o low the cycle after reset).
//  FLUSH:
//   - 8 cycles: tag_we_o=1, tag_way_o=cnt, wr_valid=0; the array has no reset.
//   - Both readies stay 0; go to IDLE after cnt=7.
//  IDLE:
//   - lookup_ready_o=1, and evict_ready_o=~lookup_valid_i (lookup has priority).
//   - Handshake latches tag/dirty; lookup -> LOOKUP, evict -> EVICT.
//  LOOKUP:
//   - tag_addr_o=latched tag. resp_valid_o=1 this cycle with hit/way/dirty from the array.
//   - Hit: PLRU touch(way), go to INVAL. Miss: go to IDLE.
//  INVAL:
//   - tag_we_o=1, tag_way_o=hit way, wr_valid=0; clear shadow bit; go to IDLE.
//   - The line has moved back to L1.
//  EVICT: tag_addr_o=evict tag; victim way is chosen and registered.
//   - Hit (duplicate): same way, dirty=latched dirty|rd_dirty.
//   - No hit and shadow not full: lowest-index invalid way.
//   - Otherwise: PLRU victim. tag_way_o=victim drives the array read.
//   - If the chosen entry is valid, dirty, and not a duplicate -> WB; else -> INSERT.
//  WB:
//   - wb_valid_o=1, wb_tag_o/wb_way_o held stable until wb_ready_i, then INSERT.
//  INSERT:
//   - tag_we_o=1, tag_way_o=victim, {valid=1, dirty, tag}.
//   - Set shadow bit, PLRU touch(victim), go to IDLE.
//  PLRU (7-bit tree):
//   - Nodes: b0 root; b1,b2 level 1; b3..b6 level 2.
//   - Bit=0 selects the lower half.
//   - touch(w): b0=~w[2]; b[1+w[2]]=~w[1]; b[3+w[2:1]]=~w[0].
//  Latency:
//   - Lookup response: 1 cycle after handshake.
//   - Clean insert: 2 cycles after handshake (EVICT, INSERT).
//   - Dirty insert: +1 cycle per WB cycle.
//  Invariants (SVA):
//   - full_i == &shadow outside FLUSH.
//   - At most one handshake per cycle.
//   - wb_* stable while wb_valid_o & ~wb_ready_i.
//   - Readies are 0 outside IDLE.
// TESTING
//  1 Reset 2 cycles, release -> tag_we_o=1 with ways 0..7, valid=0 for 8 cycles; readies go 1 on cycle 9.
//  2 Insert clean tags 0x10..0x17 back-to-back -> written to ways 0..7 in order, one every 3 cycles; full_i=1 after the 8th.
//  3 Lookup 0x13 -> next cycle resp_valid_o=1, hit=1, way=3; following cycle tag_we_o=1, way 3, valid=0.
//  4 After test 2, insert clean 0x20 with full_i=1 -> PLRU victim way 0, no wb_valid_o, INSERT writes way 0.
//  5 Victim dirty, wb_ready_i low 3 cycles -> wb_valid_o=1 for 4 cycles, tag stable; INSERT the cycle after handshake.
//  6 lookup_valid_i and evict_valid_i both high in IDLE -> lookup accepted, evict_ready_o=0; evict accepted on the next IDLE cycle.

Source files
------------

// File: rtl/victim_cache_ctrl_if.sv
// rtl/victim_cache_ctrl_if.sv - L1-side eviction/lookup/response and writeback handshakes of the victim cache controller
interface victim_cache_ctrl_if #(
  parameter int WAY_W = 3,
  parameter int TAG_W = 27
);
  logic             evict_valid_i;
  logic             evict_ready_o;
  logic [TAG_W-1:0] evict_tag_i;
  logic             evict_dirty_i;
  logic             lookup_valid_i;
  logic             lookup_ready_o;
  logic [TAG_W-1:0] lookup_tag_i;
  logic             resp_valid_o;
  logic             resp_hit_o;
  logic [WAY_W-1:0] resp_way_o;
  logic             resp_dirty_o;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [TAG_W-1:0] wb_tag_o;
  logic [WAY_W-1:0] wb_way_o;

  modport slave (
    input  evict_valid_i, evict_tag_i, evict_dirty_i, lookup_valid_i, lookup_tag_i, wb_ready_i,
    output evict_ready_o, lookup_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_dirty_o,
           wb_valid_o, wb_tag_o, wb_way_o
  );

  modport master (
    output evict_valid_i, evict_tag_i, evict_dirty_i, lookup_valid_i, lookup_tag_i, wb_ready_i,
    input  evict_ready_o, lookup_ready_o, resp_valid_o, resp_hit_o, resp_way_o, resp_dirty_o,
           wb_valid_o, wb_tag_o, wb_way_o
  );
endinterface

// File: rtl/victim_cache_ctrl.sv
// rtl/victim_cache_ctrl.sv - control FSM of the 8-way fully-associative victim cache
module victim_cache_ctrl #(
  parameter int WAYS_VC = 8,
  parameter int WAY_W   = 3,
  parameter int TAG_W   = 27
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  victim_cache_ctrl_if.slave l1,
  output logic               tag_we_o,
  output logic [WAY_W-1:0]   tag_way_o,
  output logic [TAG_W-1:0]   tag_addr_o,
  output logic               tag_wr_valid_o,
  output logic               tag_wr_dirty_o,
  output logic [TAG_W-1:0]   tag_wr_tag_o,
  input  logic               tag_hit_i,
  input  logic [WAY_W-1:0]   tag_hit_way_i,
  input  logic               tag_rd_dirty_i,
  input  logic [TAG_W-1:0]   tag_rd_tag_i,
  input  logic               full_i
);
  localparam logic [2:0] S_FLUSH  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_LOOKUP = 3'd2;
  localparam logic [2:0] S_INVAL  = 3'd3;
  localparam logic [2:0] S_EVICT  = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_INSERT = 3'd6;

  logic [2:0]         state;
  logic [WAY_W-1:0]   cnt;
  logic [6:0]         plru;
  logic [WAYS_VC-1:0] shadow;
  logic [TAG_W-1:0]   tag_q;
  logic               dirty_q;
  logic [WAY_W-1:0]   way_q;
  logic [TAG_W-1:0]   wb_tag_q;
  logic               ins_dirty_q;

  logic [WAY_W-1:0]   inv_way;
  logic [WAY_W-1:0]   plru_way;
  logic [WAY_W-1:0]   victim;
  logic               need_wb;
  logic               pw2, pw1, pw0;

  // Point every tree node on the path to w away from it.
  function automatic logic [6:0] touch(input logic [6:0] p, input logic [2:0] w);
    logic [6:0] n;
    n = p;
    n[0] = ~w[2];
    if (w[2]) n[2] = ~w[1];
    else      n[1] = ~w[1];
    case (w[2:1])
      2'd0:    n[3] = ~w[0];
      2'd1:    n[4] = ~w[0];
      2'd2:    n[5] = ~w[0];
      default: n[6] = ~w[0];
    endcase
    return n;
  endfunction

  always_comb begin
    inv_way = '0;
    for (int i = WAYS_VC - 1; i >= 0; i--) begin
      if (!shadow[i]) inv_way = WAY_W'(i);
    end
  end

  always_comb begin
    pw2 = plru[0];
    pw1 = pw2 ? plru[2] : plru[1];
    case ({pw2, pw1})
      2'd0:    pw0 = plru[3];
      2'd1:    pw0 = plru[4];
      2'd2:    pw0 = plru[5];
      default: pw0 = plru[6];
    endcase
    plru_way = {pw2, pw1, pw0};
  end

  // A duplicate reuses its own way and never needs a writeback.
  always_comb begin
    if (tag_hit_i)     victim = tag_hit_way_i;
    else if (~&shadow) victim = inv_way;
    else               victim = plru_way;
    need_wb = !tag_hit_i && shadow[victim] && tag_rd_dirty_i;
  end

  always_comb begin
    l1.evict_ready_o  = 1'b0;
    l1.lookup_ready_o = 1'b0;
    l1.resp_valid_o   = 1'b0;
    l1.resp_hit_o     = 1'b0;
    l1.resp_way_o     = '0;
    l1.resp_dirty_o   = 1'b0;
    l1.wb_valid_o     = 1'b0;
    l1.wb_tag_o       = '0;
    l1.wb_way_o       = '0;
    tag_we_o          = 1'b0;
    tag_way_o         = '0;
    tag_addr_o        = '0;
    tag_wr_valid_o    = 1'b0;
    tag_wr_dirty_o    = 1'b0;
    tag_wr_tag_o      = '0;
    if (rst_ni) begin
      case (state)
        S_FLUSH: begin
          tag_we_o  = 1'b1;
          tag_way_o = cnt;
        end
        S_IDLE: begin
          l1.lookup_ready_o = 1'b1;
          l1.evict_ready_o  = ~l1.lookup_valid_i;
        end
        S_LOOKUP: begin
          tag_addr_o      = tag_q;
          tag_way_o       = tag_hit_way_i;
          l1.resp_valid_o = 1'b1;
          l1.resp_hit_o   = tag_hit_i;
          l1.resp_way_o   = tag_hit_i ? tag_hit_way_i : '0;
          l1.resp_dirty_o = tag_hit_i & tag_rd_dirty_i;
        end
        S_INVAL: begin
          tag_we_o  = 1'b1;
          tag_way_o = way_q;
        end
        S_EVICT: begin
          tag_addr_o = tag_q;
          tag_way_o  = victim;
        end
        S_WB: begin
          l1.wb_valid_o = 1'b1;
          l1.wb_tag_o   = wb_tag_q;
          l1.wb_way_o   = way_q;
        end
        S_INSERT: begin
          tag_we_o       = 1'b1;
          tag_way_o      = way_q;
          tag_wr_valid_o = 1'b1;
          tag_wr_dirty_o = ins_dirty_q;
          tag_wr_tag_o   = tag_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_FLUSH;
      cnt         <= '0;
      plru        <= '0;
      shadow      <= '0;
      tag_q       <= '0;
      dirty_q     <= 1'b0;
      way_q       <= '0;
      wb_tag_q    <= '0;
      ins_dirty_q <= 1'b0;
    end else begin
      case (state)
        S_FLUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == WAY_W'(WAYS_VC - 1)) state <= S_IDLE;
        end
        S_IDLE: begin
          if (l1.lookup_valid_i) begin
            tag_q <= l1.lookup_tag_i;
            state <= S_LOOKUP;
          end else if (l1.evict_valid_i) begin
            tag_q   <= l1.evict_tag_i;
            dirty_q <= l1.evict_dirty_i;
            state   <= S_EVICT;
          end
        end
        S_LOOKUP: begin
          if (tag_hit_i) begin
            plru  <= touch(plru, tag_hit_way_i);
            way_q <= tag_hit_way_i;
            state <= S_INVAL;
          end else begin
            state <= S_IDLE;
          end
        end
        S_INVAL: begin
          shadow[way_q] <= 1'b0;
          state         <= S_IDLE;
        end
        S_EVICT: begin
          way_q       <= victim;
          wb_tag_q    <= tag_rd_tag_i;
          ins_dirty_q <= dirty_q | (tag_hit_i & tag_rd_dirty_i);
          state       <= need_wb ? S_WB : S_INSERT;
        end
        S_WB: begin
          if (l1.wb_ready_i) state <= S_INSERT;
        end
        S_INSERT: begin
          shadow[way_q] <= 1'b1;
          plru          <= touch(plru, way_q);
          state         <= S_IDLE;
        end
        default: state <= S_FLUSH;
      endcase
    end
  end

  a_full_tracks_shadow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state != S_FLUSH) |-> (full_i == &shadow));
  a_one_handshake: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(l1.evict_valid_i && l1.evict_ready_o && l1.lookup_valid_i && l1.lookup_ready_o));
  a_wb_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (l1.wb_valid_o && !l1.wb_ready_i) |=> (l1.wb_valid_o && $stable(l1.wb_tag_o) && $stable(l1.wb_way_o)));
  a_ready_idle_only: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state != S_IDLE) |-> (!l1.evict_ready_o && !l1.lookup_ready_o));
endmodule
